// File: rtl/token_access_arbiter.sv
// Round-robin token-authenticated arbiter that steers confirmed data words into a shared P/Q register pair.
// Optional AUTH wait timeout is compiled in with `define TOKEN_ARB_TIMEOUT_EN.
module token_access_arbiter #(
  parameter int NREQ         = 4,
  parameter int TOKEN_W      = 3,
  parameter int DATA_W       = 8,
  parameter int MAX_FAIL     = 3,
  parameter int LOCK_CYCLES  = 16,
  parameter int AUTH_TIMEOUT = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           confirm,
  input  logic [NREQ*TOKEN_W-1:0]   user_token,
  input  logic [NREQ*DATA_W-1:0]    time_data,
  input  logic [TOKEN_W-1:0]        system_token,
  output logic [NREQ-1:0]           grant,
  output logic                      busy,
  output logic                      load_p,
  output logic                      load_q,
  output logic [DATA_W-1:0]         data_out,
  output logic [NREQ-1:0]           locked,
  output logic                      fail_pulse
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

  if (NREQ < 2 || NREQ > 8 || DATA_W < 8 || TOKEN_W < 1 || MAX_FAIL < 1 ||
      LOCK_CYCLES < 1 || AUTH_TIMEOUT < 1) begin : g_bad_params
    $error("token_access_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_AUTH,
    S_SERVE,
    S_DENY
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               load_p_q, load_p_d;
  logic               load_q_q, load_q_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               fail_pulse_q, fail_pulse_d;
  logic [NREQ-1:0]    locked_q, locked_d;
  logic [CNT_W-1:0]   fail_cnt_q [NREQ];
  logic [CNT_W-1:0]   fail_cnt_d [NREQ];
  logic [TMR_W-1:0]   lock_tmr_q [NREQ];
  logic [TMR_W-1:0]   lock_tmr_d [NREQ];

`ifdef TOKEN_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(AUTH_TIMEOUT + 1);
  logic [TO_W-1:0]    auth_cnt_q, auth_cnt_d;
`endif

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic               fail;
  logic [CNT_W-1:0]   cnt_next;

  // Everything about the currently granted requester, selected once.
  logic               g_req;
  logic               g_conf;
  logic               tok_ok;
  logic [DATA_W-1:0]  g_data;

  assign g_req  = req[gidx_q];
  assign g_conf = confirm[gidx_q];
  assign tok_ok = (user_token[int'(gidx_q)*TOKEN_W +: TOKEN_W] == system_token);
  assign g_data = time_data[int'(gidx_q)*DATA_W +: DATA_W];

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    gidx_d       = gidx_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    load_p_d     = 1'b0;
    load_q_d     = 1'b0;
    data_d       = data_q;
    fail_pulse_d = 1'b0;
    locked_d     = locked_q;
    fail_cnt_d   = fail_cnt_q;
    lock_tmr_d   = lock_tmr_q;
    found        = 1'b0;
    pick         = '0;
    fail         = 1'b0;
    cnt_next     = '0;
`ifdef TOKEN_ARB_TIMEOUT_EN
    auth_cnt_d   = auth_cnt_q;
`endif

    for (int i = 0; i < NREQ; i++) begin
      if (lock_tmr_q[i] != '0) begin
        lock_tmr_d[i] = lock_tmr_q[i] - 1'b1;
        if (lock_tmr_q[i] == TMR_W'(1)) locked_d[i] = 1'b0;
      end
    end

    // Search starts at the round-robin pointer and wraps; the lock view is this cycle's.
    for (int k = 0; k < NREQ; k++) begin
      int cand;
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand] && !locked_q[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = S_AUTH;
`ifdef TOKEN_ARB_TIMEOUT_EN
          auth_cnt_d    = '0;
`endif
        end
      end
      S_AUTH: begin
        // A request drop here abandons the attempt without advancing the pointer.
        if (!g_req) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (g_conf) begin
          if (tok_ok) begin
            fail_cnt_d[gidx_q] = '0;
            state_d            = S_SERVE;
          end else begin
            fail = 1'b1;
          end
        end
`ifdef TOKEN_ARB_TIMEOUT_EN
        else if (auth_cnt_q == TO_W'(AUTH_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          auth_cnt_d = auth_cnt_q + 1'b1;
        end
`endif
      end
      S_SERVE: begin
        if (!g_req) begin
          grant_d = '0;
          rr_d    = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          state_d = S_IDLE;
        end else if (g_conf) begin
          data_d = g_data;
          if (g_data[7:4] == 4'hF) load_p_d = 1'b1;
          else                     load_q_d = 1'b1;
        end
      end
      S_DENY: begin
        if (!g_req) begin
          grant_d = '0;
          rr_d    = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      fail_pulse_d = 1'b1;
      state_d      = S_DENY;
      cnt_next     = (fail_cnt_q[gidx_q] == CNT_W'(MAX_FAIL)) ? fail_cnt_q[gidx_q]
                                                               : fail_cnt_q[gidx_q] + 1'b1;
      if (cnt_next == CNT_W'(MAX_FAIL)) begin
        locked_d[gidx_q]   = 1'b1;
        lock_tmr_d[gidx_q] = TMR_W'(LOCK_CYCLES);
        fail_cnt_d[gidx_q] = '0;
      end else begin
        fail_cnt_d[gidx_q] = cnt_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gidx_q       <= '0;
      rr_q         <= '0;
      grant_q      <= '0;
      load_p_q     <= 1'b0;
      load_q_q     <= 1'b0;
      data_q       <= '0;
      fail_pulse_q <= 1'b0;
      locked_q     <= '0;
      // NOTE: the per-requester arrays are plain flops holding live state, so they are reset too.
      for (int i = 0; i < NREQ; i++) begin
        fail_cnt_q[i] <= '0;
        lock_tmr_q[i] <= '0;
      end
`ifdef TOKEN_ARB_TIMEOUT_EN
      auth_cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      load_p_q     <= load_p_d;
      load_q_q     <= load_q_d;
      data_q       <= data_d;
      fail_pulse_q <= fail_pulse_d;
      locked_q     <= locked_d;
      fail_cnt_q   <= fail_cnt_d;
      lock_tmr_q   <= lock_tmr_d;
`ifdef TOKEN_ARB_TIMEOUT_EN
      auth_cnt_q   <= auth_cnt_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != S_IDLE);
  assign load_p     = load_p_q;
  assign load_q     = load_q_q;
  assign data_out   = data_q;
  assign locked     = locked_q;
  assign fail_pulse = fail_pulse_q;

endmodule

// File: tb/tb_token_access_arbiter.sv
// Self-checking bench for token_access_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_token_access_arbiter;

  localparam int         N       = 4;
  localparam logic [2:0] SYS_TOK = 3'b101;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0]      confirm;
  logic [2:0]        tok [N];
  logic [7:0]        dat [N];
  logic [N*3-1:0]    user_token;
  logic [N*8-1:0]    time_data;
  logic [N-1:0]      grant;
  logic              busy;
  logic              load_p;
  logic              load_q;
  logic [7:0]        data_out;
  logic [N-1:0]      locked;
  logic              fail_pulse;

  assign user_token = {tok[3], tok[2], tok[1], tok[0]};
  assign time_data  = {dat[3], dat[2], dat[1], dat[0]};

  token_access_arbiter #(
    .NREQ(N), .TOKEN_W(3), .DATA_W(8), .MAX_FAIL(3), .LOCK_CYCLES(16), .AUTH_TIMEOUT(32)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .confirm(confirm),
    .user_token(user_token), .time_data(time_data), .system_token(SYS_TOK),
    .grant(grant), .busy(busy), .load_p(load_p), .load_q(load_q),
    .data_out(data_out), .locked(locked), .fail_pulse(fail_pulse)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: who owns the resource and in which phase, plus per-requester bookkeeping.
  localparam int WAIT_TOKEN = 0, SERVING = 1, DENIED = 2;
  int         owner = -1;
  int         mode  = WAIT_TOKEN;
  int         next_start = 0;
  int         fail_count [N];
  int         lock_left  [N];
  logic [N-1:0] e_grant;
  logic         e_lp, e_lq, e_fail;
  logic [7:0]   e_data;
  logic [N-1:0] prev_grant;

  task automatic model_step();
    logic [N-1:0] lk_now;
    bit           hit;
    e_lp = 1'b0; e_lq = 1'b0; e_fail = 1'b0;
    if (reset) begin
      owner = -1; mode = WAIT_TOKEN; next_start = 0; e_data = 8'h00;
      for (int i = 0; i < N; i++) begin fail_count[i] = 0; lock_left[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) lk_now[i] = (lock_left[i] > 0);
      for (int i = 0; i < N; i++) if (lock_left[i] > 0) lock_left[i]--;
      if (owner < 0) begin
        hit = 0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (next_start + k) % N;
          if (!hit && req[c] && !lk_now[c]) begin hit = 1; owner = c; mode = WAIT_TOKEN; end
        end
      end else if (!req[owner]) begin
        if (mode != WAIT_TOKEN) next_start = (owner + 1) % N;
        owner = -1;
      end else if (mode == WAIT_TOKEN && confirm[owner]) begin
        if (tok[owner] == SYS_TOK) begin
          fail_count[owner] = 0; mode = SERVING;
        end else begin
          e_fail = 1'b1; mode = DENIED;
          fail_count[owner]++;
          if (fail_count[owner] >= 3) begin fail_count[owner] = 0; lock_left[owner] = 16; end
        end
      end else if (mode == SERVING && confirm[owner]) begin
        e_data = dat[owner];
        if (dat[owner] >= 8'hF0) e_lp = 1'b1; else e_lq = 1'b1;
      end
    end
    e_grant = (owner < 0) ? '0 : (N'(1) << owner);
  endtask

  task automatic compare_all();
    logic [N-1:0] e_locked;
    for (int i = 0; i < N; i++) e_locked[i] = (lock_left[i] > 0);
    check("grant", grant, e_grant);
    check("busy", busy, (owner >= 0));
    check("load_p", load_p, e_lp);
    check("load_q", load_q, e_lq);
    check("fail_pulse", fail_pulse, e_fail);
    check("locked", locked, e_locked);
    check("load_excl", load_p & load_q, 0);
    check("grant_gap", (prev_grant != 0 && grant != 0 && grant != prev_grant), 0);
    if (e_lp || e_lq) check("data_out", data_out, e_data);
    prev_grant = grant;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  int order [4];
  int exp_order [4] = '{0, 1, 3, 0};
  int waited;
  int lock_obs;
  logic [N-1:0] g_saved;

  initial begin
    reset = 1'b1; req = '0; confirm = '0; prev_grant = '0;
    for (int i = 0; i < N; i++) begin tok[i] = SYS_TOK; dat[i] = 8'h00; end
    tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_outputs", {busy, load_p, load_q, fail_pulse, locked, data_out}, 0);
    reset = 1'b0;

    // Authenticate requester 1 and write to P, then to Q, then release.
    req = 4'b0010; tick();
    check("p_grant", grant, 4'b0010);
    confirm[1] = 1'b1; tick();
    dat[1] = 8'hF3; tick(); confirm[1] = 1'b0;
    check("p_load", load_p, 1);
    check("p_noq", load_q, 0);
    check("p_data", data_out, 8'hF3);
    tick();
    check("p_single", load_p, 0);
    dat[1] = 8'h5A; confirm[1] = 1'b1; tick(); confirm[1] = 1'b0;
    check("q_load", load_q, 1);
    check("q_data", data_out, 8'h5A);
    req = 4'b0000; tick();
    check("q_release", grant, 0);
    req = 4'b0111; tick();
    check("rr_after_drop", grant, 4'b0100);
    req = '0; tick(); tick();

    // Round-robin with req=1011 held, each grant released through SERVE.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      while (grant == '0 && waited < 10) begin tick(); waited++; end
      check("rr_grant_seen", (grant != '0), 1);
      g_saved  = grant;
      order[n] = -1;
      for (int i = 0; i < N; i++) if (g_saved[i]) order[n] = i;
      confirm = g_saved; tick(); confirm = '0;
      req = req & ~g_saved; tick(); req = 4'b1011;
    end
    for (int n = 0; n < 4; n++) check("rr_order", order[n], exp_order[n]);
    req = '0; tick();

    // Lockout of requester 2 after three bad tokens.
    reset = 1'b1; tick(); reset = 1'b0;
    tok[2] = 3'b010; req = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("lk_grant", grant, 4'b0100);
      confirm[2] = 1'b1; tick(); confirm[2] = 1'b0;
      check("lk_fail_pulse", fail_pulse, 1);
      check("lk_flag", locked[2], (n == 2));
      if (n < 2) begin req[2] = 1'b0; tick(); req[2] = 1'b1; end
    end
    lock_obs = 1;
    req[2] = 1'b0; tick(); req[2] = 1'b1;
    if (locked[2]) lock_obs++;
    waited = 0;
    while (grant != 4'b0100 && waited < 40) begin
      tick(); waited++;
      if (locked[2]) lock_obs++;
    end
    check("lk_regrant", grant, 4'b0100);
    check("lk_duration", lock_obs, 16);
    tok[2] = SYS_TOK; req = '0; tick();

    // Reset arriving with a P-destined confirm in SERVE.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0001; tick();
    confirm[0] = 1'b1; tick();
    dat[0] = 8'hFF; reset = 1'b1; tick();
    check("rs_no_load", load_p, 0);
    check("rs_outputs", {grant, busy, load_q, fail_pulse, locked, data_out}, 0);
    reset = 1'b0; confirm = '0; req = '0; tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) req[i] = ~req[i];
        confirm[i] = ($urandom_range(2) == 0);
        tok[i]     = ($urandom_range(3) != 0) ? SYS_TOK : 3'($urandom);
        dat[i]     = ($urandom_range(1) == 0) ? {4'hF, 4'($urandom)} : 8'($urandom);
      end
      reset = ($urandom_range(299) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
